// File: rtl/fb_writer_pkg.sv
// Shared constants and encodings for the frame buffer writer.
package fb_writer_pkg;
  localparam int NPIX_DEF   = 1024;
  localparam int NBYTES_DEF = 1536;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 6;
  localparam int BYTE_W     = 11;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  localparam logic [1:0] WR_EN_NONE = 2'b00;
  localparam logic [1:0] WR_EN_LO   = 2'b01;
  localparam logic [1:0] WR_EN_HI   = 2'b10;
endpackage

// File: rtl/fb_unpack.sv
// Turns a 3-byte group into two 12-bit pixels; pix_vld is combinational on the
// byte that completes a pixel. clr returns the phase to the first byte.
module fb_unpack (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  input  logic        clr,
  output logic        pix_vld,
  output logic [11:0] pix_dat
);
  logic [1:0] phase_q, phase_d;
  logic [7:0] lo_q, lo_d;
  logic [3:0] nib_q, nib_d;

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    nib_d   = nib_q;
    pix_vld = 1'b0;
    pix_dat = 12'h000;
    if (in_vld) begin
      case (phase_q)
        2'd0: begin
          lo_d    = in_dat;
          phase_d = 2'd1;
        end
        2'd1: begin
          pix_vld = 1'b1;
          pix_dat = {in_dat[3:0], lo_q};
          nib_d   = in_dat[7:4];
          phase_d = 2'd2;
        end
        default: begin
          pix_vld = 1'b1;
          pix_dat = {in_dat, nib_q};
          phase_d = 2'd0;
        end
      endcase
    end
    if (clr) phase_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q <= 2'd0;
      lo_q    <= 8'h00;
      nib_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      nib_q   <= nib_d;
    end
  end
endmodule

// File: rtl/fb_writer.sv
// Double-buffered frame writer: fills the hidden bank from a byte stream, then
// waits for a scanner rising edge on disp_done to swap banks.
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int NPIX   = NPIX_DEF,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        disp_done,
  output logic [9:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic [1:0]  wr_en,
  output logic        rd_bank,
  output logic        frame_ok,
  output logic        frame_err
);
  localparam int PIX_W = $clog2(NPIX);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic               disp_done_q;
  logic [1:0]         wr_en_q, wr_en_d;
  logic [9:0]         wr_addr_q, wr_addr_d;
  logic [23:0]        wr_data_q, wr_data_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               accept, is_last_byte, unpack_clr, pix_vld;
  logic [11:0]        pix_dat;

  assign s_ready      = rstn & (state_q == FILL);
  assign accept       = s_valid & s_ready;
  assign is_last_byte = (byte_cnt_q == LAST_BYTE);

  fb_unpack u_unpack (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (accept),
    .in_dat  (s_data),
    .clr     (unpack_clr),
    .pix_vld (pix_vld),
    .pix_dat (pix_dat)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    rd_bank_d   = rd_bank_q;
    wr_en_d     = WR_EN_NONE;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    unpack_clr  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          // s_last must coincide exactly with the final byte index
          if (s_last != is_last_byte) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            pix_cnt_d   = '0;
            unpack_clr  = 1'b1;
          end else begin
            if (pix_vld) begin
              wr_en_d   = pix_cnt_q[PIX_W-1] ? WR_EN_HI : WR_EN_LO;
              wr_addr_d = {~rd_bank_q, pix_cnt_q[PIX_W-2:0]};
              wr_data_d = {pix_dat, pix_dat};
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
            if (is_last_byte) begin
              frame_ok_d = 1'b1;
              byte_cnt_d = '0;
              pix_cnt_d  = '0;
              unpack_clr = 1'b1;
              state_d    = WAIT_SWAP;
            end else begin
              byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (disp_done && !disp_done_q) begin
          rd_bank_d  = ~rd_bank_q;
          byte_cnt_d = '0;
          pix_cnt_d  = '0;
          unpack_clr = 1'b1;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FILL;
      byte_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      rd_bank_q   <= 1'b0;
      disp_done_q <= 1'b0;
      wr_en_q     <= WR_EN_NONE;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      rd_bank_q   <= rd_bank_d;
      disp_done_q <= disp_done;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_bank   = rd_bank_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_fb_writer.sv
// Directed frame sequence with random pixel data; expected writes, pulses and
// bank state come from a byte-stream reference model.
module tb_fb_writer;
  localparam int NB = 1536;

  logic        clk = 1'b0;
  logic        rstn, s_valid, s_last, disp_done;
  logic [7:0]  s_data;
  logic        s_ready, rd_bank, frame_ok, frame_err;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic [1:0]  wr_en;

  always #5 clk = ~clk;

  fb_writer dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .disp_done(disp_done), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .rd_bank(rd_bank), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [23:0] data;
    logic [1:0]  en;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_w;
  int   cyc = 0, ncmp = 0, nfail = 0;
  int   wr_cnt = 0, ok_cnt = 0, err_cnt = 0;
  int   exp_ok_cyc = -1, exp_err_cyc = -1;
  int   w0, o0, e0;
  bit   model_bank = 1'b0, model_fill = 1'b1, run = 1'b0;
  logic [7:0] fbuf [0:NB-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (run) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_w = exp_q.pop_front();
        chk("wr_en", {30'b0, wr_en}, {30'b0, mon_w.en});
        chk("wr_addr", {22'b0, wr_addr}, {22'b0, mon_w.addr});
        chk("wr_data", {8'b0, wr_data}, {8'b0, mon_w.data});
      end else begin
        chk("wr_en_idle", {30'b0, wr_en}, 32'd0);
      end
      if (wr_en != 2'b00) wr_cnt++;
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      chk("frame_ok", {31'b0, frame_ok}, {31'b0, cyc == exp_ok_cyc});
      chk("frame_err", {31'b0, frame_err}, {31'b0, cyc == exp_err_cyc});
      chk("rd_bank", {31'b0, rd_bank}, {31'b0, model_bank});
      chk("s_ready", {31'b0, s_ready}, {31'b0, rstn && model_fill});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_pix(input int n, input logic [11:0] p, input int wb);
    wr_t w;
    w.cyc  = cyc;
    w.addr = 10'(wb * 512 + (n % 512));
    w.en   = (n >= 512) ? 2'b10 : 2'b01;
    w.data = {p, p};
    exp_q.push_back(w);
  endtask

  // Sends fbuf[start..nb-1]; stops after a terminating byte (good end or error).
  task automatic send_frame(input int start, input int nb, input int last_at, input bit gaps);
    bit last, good, bad;
    int wb;
    wb = model_bank ? 0 : 1;
    for (int i = start; i < nb; i++) begin
      last = (i == last_at);
      good = last && (i == NB - 1);
      bad  = (last && i < NB - 1) || (i == NB - 1 && !last);
      s_data = fbuf[i]; s_valid = 1'b1; s_last = last;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
      if (!bad) begin
        if (i % 3 == 1) push_pix(2 * (i / 3), {fbuf[i][3:0], fbuf[i-1]}, wb);
        else if (i % 3 == 2) push_pix(2 * (i / 3) + 1, {fbuf[i], fbuf[i-1][7:4]}, wb);
      end
      if (good) begin exp_ok_cyc = cyc; model_fill = 1'b0; end
      if (bad) exp_err_cyc = cyc;
      if (good || bad) break;
      if (gaps && $urandom_range(0, 7) == 0) idle(1);
    end
  endtask

  task automatic set_dd(input logic v);
    logic old;
    old = disp_done;
    disp_done = v;
    @(posedge clk); #1;
    if (!model_fill && !old && v) begin
      model_bank = ~model_bank;
      model_fill = 1'b1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) fbuf[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    model_bank = 1'b0; model_fill = 1'b1;
    idle(2);
    rstn = 1'b1;
  endtask

  task automatic snap();
    w0 = wr_cnt; o0 = ok_cnt; e0 = err_cnt;
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; disp_done = 1'b0;
    idle(2);
    run = 1'b1;
    chk("rst_rd_bank", {31'b0, rd_bank}, 32'd0);
    chk("rst_wr_en", {30'b0, wr_en}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    rstn = 1'b1;
    #1 chk("post_rst_s_ready", {31'b0, s_ready}, 32'd1);

    // Fixed pattern frame into bank 1
    for (int i = 0; i < NB; i++) fbuf[i] = (i % 3 == 0) ? 8'h21 : (i % 3 == 1) ? 8'h43 : 8'h65;
    snap();
    send_frame(0, NB, NB - 1, 1'b0);
    idle(2);
    chk("A_writes", wr_cnt - w0, 32'd1024);
    chk("A_ok", ok_cnt - o0, 32'd1);
    chk("A_err", err_cnt - e0, 32'd0);
    set_dd(1'b1);
    chk("A_swap_bank", {31'b0, rd_bank}, 32'd1);
    chk("A_swap_ready", {31'b0, s_ready}, 32'd1);
    set_dd(1'b0);

    // Random frame into bank 0, disp_done raised mid-frame and held
    fill_random();
    snap();
    send_frame(0, 800, -1, 1'b1);
    set_dd(1'b1);
    send_frame(800, NB, NB - 1, 1'b1);
    idle(6);
    chk("B_writes", wr_cnt - w0, 32'd1024);
    chk("B_noswap_bank", {31'b0, rd_bank}, 32'd1);
    chk("B_wait_ready", {31'b0, s_ready}, 32'd0);
    set_dd(1'b0);
    idle(3);
    set_dd(1'b1);
    chk("B_swap_bank", {31'b0, rd_bank}, 32'd0);
    set_dd(1'b0);

    // Early s_last on byte 299
    fill_random();
    snap();
    send_frame(0, NB, 299, 1'b1);
    idle(2);
    chk("C_writes", wr_cnt - w0, 32'd199);
    chk("C_err", err_cnt - e0, 32'd1);
    chk("C_ok", ok_cnt - o0, 32'd0);
    chk("C_bank", {31'b0, rd_bank}, 32'd0);

    fill_random();
    snap();
    send_frame(0, NB, NB - 1, 1'b1);
    idle(2);
    chk("D_writes", wr_cnt - w0, 32'd1024);
    chk("D_ok", ok_cnt - o0, 32'd1);
    set_dd(1'b1);
    set_dd(1'b0);
    chk("D_bank", {31'b0, rd_bank}, 32'd1);

    // Final byte without s_last
    fill_random();
    snap();
    send_frame(0, NB, -1, 1'b1);
    idle(2);
    chk("E_err", err_cnt - e0, 32'd1);
    chk("E_ok", ok_cnt - o0, 32'd0);
    set_dd(1'b1);
    set_dd(1'b0);
    chk("E_bank", {31'b0, rd_bank}, 32'd1);

    // Reset in the middle of a frame
    fill_random();
    snap();
    send_frame(0, 700, -1, 1'b0);
    do_reset();
    chk("F_bank", {31'b0, rd_bank}, 32'd0);
    chk("F_wr_en", {30'b0, wr_en}, 32'd0);
    chk("F_pulses", (ok_cnt - o0) + (err_cnt - e0), 32'd0);
    fill_random();
    snap();
    send_frame(0, NB, NB - 1, 1'b1);
    idle(2);
    chk("G_writes", wr_cnt - w0, 32'd1024);
    chk("G_ok", ok_cnt - o0, 32'd1);
    set_dd(1'b1);
    chk("G_bank", {31'b0, rd_bank}, 32'd1);
    set_dd(1'b0);

    chk("pending_writes", exp_q.size(), 32'd0);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
